// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Fetch-PC control FSM. Handles start-up, stall/branch arbitration,
//             post-branch squash, halt/restart, and the run-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int INIT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Init_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_stall,
  input  logic             hazard,
  input  logic             br_taken,
  input  logic [2:0]       br_target,
  output logic             pc_init,
  output logic             pc_stall,
  output logic             pc_branch,
  output logic [2:0]       pc_target,
  output logic             pc_done,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int c_INIT_W  = (INIT_CYCLES  > 1) ? $clog2(INIT_CYCLES)  : 1;
  localparam int c_FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_INIT_W-1:0]  c_INIT_LOAD  = c_INIT_W'(INIT_CYCLES - 1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LOAD =
    c_FLUSH_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [c_INIT_W-1:0]  r_init_cnt,  w_init_nxt;
  logic [c_FLUSH_W-1:0] r_flush_cnt, w_flush_nxt;
  logic [CNT_W-1:0]     r_cycle_cnt, w_cnt_nxt;
  logic                 w_stall_src;
  logic                 w_active;

  assign w_stall_src = mem_stall | hazard;
  assign w_active    = (r_state == S_RUN) || (r_state == S_FLUSH);

  assign pc_init   = (r_state == S_IDLE) || (r_state == S_INIT);
  assign pc_done   = (r_state == S_HALT);
  assign busy      = (r_state == S_INIT) || w_active;
  assign cycle_cnt = r_cycle_cnt;

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      r_state     <= S_IDLE;
      r_init_cnt  <= '0;
      r_flush_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_cycle_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init_cnt;
    w_flush_nxt = r_flush_cnt;
    w_cnt_nxt   = r_cycle_cnt;
    pc_stall    = 1'b0;
    pc_branch   = 1'b0;
    pc_target   = 3'd0;
    flush       = 1'b0;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_INIT;
          w_init_nxt  = c_INIT_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_INIT: begin
        if (r_init_cnt == '0) w_state_nxt = S_RUN;
        else                  w_init_nxt  = r_init_cnt - c_INIT_W'(1);
      end
      S_RUN: begin
        if (halt_req) begin
          pc_stall    = 1'b1;
          w_state_nxt = S_HALT;
        end else if (w_stall_src) begin
          // A branch resolved during a stall is dropped; its source re-presents it.
          pc_stall = 1'b1;
        end else if (br_taken) begin
          pc_branch = 1'b1;
          pc_target = br_target;
          if (FLUSH_CYCLES > 0) begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = c_FLUSH_LOAD;
          end
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (halt_req) begin
          pc_stall    = 1'b1;
          w_state_nxt = S_HALT;
        end else if (w_stall_src) begin
          pc_stall = 1'b1;
        end else if (r_flush_cnt == '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_flush_nxt = r_flush_cnt - c_FLUSH_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Counts only productive run cycles and sticks at all-ones.
    if (w_active && !pc_stall && (r_cycle_cnt != '1))
      w_cnt_nxt = r_cycle_cnt + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Directed scoreboard bench for fetch_sequencer (two parameter sets).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;

  logic       a_start, a_halt, a_ms, a_hz, a_br;
  logic [2:0] a_tgt;
  logic       a_init, a_stall, a_branch, a_done, a_flush, a_busy;
  logic [2:0] a_ptgt;
  logic [15:0] a_cnt;

  logic       b_start, b_halt, b_ms, b_hz, b_br;
  logic [2:0] b_tgt;
  logic       b_init, b_stall, b_branch, b_done, b_flush, b_busy;
  logic [2:0] b_ptgt;
  logic [3:0] b_cnt;

  fetch_sequencer #(.INIT_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .CLK(clk), .Init_n(rst_n), .start(a_start), .halt_req(a_halt),
    .mem_stall(a_ms), .hazard(a_hz), .br_taken(a_br), .br_target(a_tgt),
    .pc_init(a_init), .pc_stall(a_stall), .pc_branch(a_branch),
    .pc_target(a_ptgt), .pc_done(a_done), .flush(a_flush), .busy(a_busy),
    .cycle_cnt(a_cnt)
  );

  fetch_sequencer #(.INIT_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .CLK(clk), .Init_n(rst_n), .start(b_start), .halt_req(b_halt),
    .mem_stall(b_ms), .hazard(b_hz), .br_taken(b_br), .br_target(b_tgt),
    .pc_init(b_init), .pc_stall(b_stall), .pc_branch(b_branch),
    .pc_target(b_ptgt), .pc_done(b_done), .flush(b_flush), .busy(b_busy),
    .cycle_cnt(b_cnt)
  );

  typedef struct {
    int       tag;
    bit       sel;
    bit [8:0] flags;   // {init, stall, branch, target[2:0], done, flush, busy}
    int       cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t     e;
      bit [8:0] got;
      int       gcnt;
      e = q.pop_front();
      if (e.sel) begin
        got  = {b_init, b_stall, b_branch, b_ptgt, b_done, b_flush, b_busy};
        gcnt = int'(b_cnt);
      end else begin
        got  = {a_init, a_stall, a_branch, a_ptgt, a_done, a_flush, a_busy};
        gcnt = int'(a_cnt);
      end
      tests++;
      if (got !== e.flags || gcnt != e.cnt) begin
        fails++;
        $display("FAIL vec%0d dut%0s: got {init,stall,br,tgt,done,flush,busy}=%b cnt=%0d, required %b cnt=%0d",
                 e.tag, e.sel ? "B" : "A", got, gcnt, e.flags, e.cnt);
      end
    end
  end

  task automatic push(input bit sel, input bit ei, es, eb, input logic [2:0] et,
                      input bit ed, ef, ebz, input int ec);
    exp_t e;
    e.tag   = vec_id;
    e.sel   = sel;
    e.flags = {ei, es, eb, et, ed, ef, ebz};
    e.cnt   = ec;
    q.push_back(e);
    vec_id++;
  endtask

  task automatic v(input bit sel, input bit st, hr, ms, hz, bt, input logic [2:0] tg,
                   input bit ei, es, eb, input logic [2:0] et,
                   input bit ed, ef, ebz, input int ec);
    @(posedge clk);
    #1;
    {a_start, a_halt, a_ms, a_hz, a_br, a_tgt} = '0;
    {b_start, b_halt, b_ms, b_hz, b_br, b_tgt} = '0;
    if (sel) {b_start, b_halt, b_ms, b_hz, b_br, b_tgt} = {st, hr, ms, hz, bt, tg};
    else     {a_start, a_halt, a_ms, a_hz, a_br, a_tgt} = {st, hr, ms, hz, bt, tg};
    push(sel, ei, es, eb, et, ed, ef, ebz, ec);
  endtask

  // Reset asserted mid-cycle with stall/branch inputs live; checked before the next edge.
  task automatic reset_mid_b();
    @(posedge clk);
    #1;
    b_ms = 1'b1; b_br = 1'b1; b_tgt = 3'd4;
    #2 rst_n = 1'b0;
    push(1, 1, 0, 0, 3'd0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_start, a_halt, a_ms, a_hz, a_br, a_tgt} = '0;
    {b_start, b_halt, b_ms, b_hz, b_br, b_tgt} = '0;
    //     sel st hr ms hz bt tg   init stl br tgt done fl busy cnt
    v(0, 0, 0, 1, 0, 1, 3'd2,  1, 0, 0, 3'd0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Start-up, branch with 1-cycle squash, stall vs branch, halt/restart.
    v(0, 1, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 3'd5,  0, 0, 1, 3'd5, 0, 0, 1, 1);
    v(0, 0, 0, 0, 0, 1, 3'd6,  0, 0, 0, 3'd0, 0, 1, 1, 2);
    v(0, 0, 0, 0, 0, 0, 3'd7,  0, 0, 0, 3'd0, 0, 0, 1, 3);
    v(0, 0, 0, 1, 0, 1, 3'd2,  0, 1, 0, 3'd0, 0, 0, 1, 4);
    v(0, 0, 0, 0, 1, 1, 3'd2,  0, 1, 0, 3'd0, 0, 0, 1, 4);
    v(0, 0, 0, 0, 0, 1, 3'd2,  0, 0, 1, 3'd2, 0, 0, 1, 4);
    v(0, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 1, 1, 5);
    v(0, 0, 1, 1, 0, 1, 3'd3,  0, 1, 0, 3'd0, 0, 0, 1, 6);
    v(0, 0, 1, 0, 0, 1, 3'd3,  0, 0, 0, 3'd0, 1, 0, 0, 6);
    v(0, 0, 0, 1, 1, 0, 3'd0,  0, 0, 0, 3'd0, 1, 0, 0, 6);
    v(0, 1, 1, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 1, 0, 0, 6);
    v(0, 1, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 0, 1, 1);

    // Two-cycle squash with stalls inside it, counter saturation, async reset.
    v(1, 1, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 1, 3'd3,  0, 0, 1, 3'd3, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 1, 1, 1);
    v(1, 0, 0, 1, 0, 0, 3'd0,  0, 1, 0, 3'd0, 0, 1, 1, 2);
    v(1, 0, 0, 0, 1, 0, 3'd0,  0, 1, 0, 3'd0, 0, 1, 1, 2);
    v(1, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 1, 1, 2);
    v(1, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 0, 1, 3);
    for (int k = 0; k < 20; k++)
      v(1, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 0, 1, (4 + k > 15) ? 15 : 4 + k);
    v(1, 0, 0, 0, 0, 1, 3'd1,  0, 0, 1, 3'd1, 0, 0, 1, 15);
    v(1, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 0, 1, 1, 15);
    reset_mid_b();

    // Halt arriving during a squash.
    v(1, 1, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 3'd0,  1, 0, 0, 3'd0, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 1, 3'd7,  0, 0, 1, 3'd7, 0, 0, 1, 0);
    v(1, 0, 1, 0, 0, 0, 3'd0,  0, 1, 0, 3'd0, 0, 1, 1, 1);
    v(1, 0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 3'd0, 1, 0, 0, 1);

    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
